// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read/write arbiter.
//   BURST_INCR  : fixed burst type driven on AR/AW.
//   wr_state_e  : write-path state machine encoding.
//   compose_id  : builds an outer ID from a requester index (upper bits zero).
//   next_rr     : round-robin pointer advance, modulo the requester count.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         MAX_ID_W   = 16;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Keep only the low idx_w bits of the index; everything above is zero.
    function automatic logic [MAX_ID_W-1:0] compose_id(input logic [MAX_ID_W-1:0] idx,
                                                       input int                  idx_w);
        logic [MAX_ID_W-1:0] mask;
        mask = (MAX_ID_W'(1) << idx_w) - MAX_ID_W'(1);
        return idx & mask;
    endfunction

    // The winner moves to lowest priority on the next arbitration.
    function automatic int next_rr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       in  N   request vector
//   ptr       in  IW  highest-priority index for this arbitration
//   gnt_idx   out IW  first requester at or after ptr (wrapping)
//   gnt_valid out 1   some requester is active
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        int cand;
        // NOTE: every always_comb output gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_arbiter_rr.sv
// AXI3 master-side arbiter: NUM_RD read and NUM_WR write requesters onto one
// outer AXI port.
//   clk, rst        : clock; asynchronous active-low reset
//   m_ar*/m_r*      : per-requester read address / read data (packed slices)
//   m_aw*/m_w*/m_b* : per-requester write address / data / response
//   ar*/r*/aw*/w*/b*: outer AXI3 port
//   err_rid         : sticky flag, a read beat arrived with an unroutable RID
// Reads: registered round-robin AR grant, R routed by RID (many in flight).
// Writes: one burst at a time through an AW -> W -> B state machine.
module axi_arbiter_rr
    import axi_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int IDX_W  = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    // read requesters
    input  logic [NUM_RD*ADDR_W-1:0] m_araddr,
    input  logic [NUM_RD*4-1:0]      m_arlen,
    input  logic [NUM_RD*3-1:0]      m_arsize,
    input  logic [NUM_RD-1:0]        m_arvalid,
    output logic [NUM_RD-1:0]        m_arready,
    output logic [NUM_RD*DATA_W-1:0] m_rdata,
    output logic [NUM_RD*2-1:0]      m_rresp,
    output logic [NUM_RD-1:0]        m_rlast,
    output logic [NUM_RD-1:0]        m_rvalid,
    input  logic [NUM_RD-1:0]        m_rready,
    // write requesters
    input  logic [NUM_WR*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_WR*4-1:0]      m_awlen,
    input  logic [NUM_WR*3-1:0]      m_awsize,
    input  logic [NUM_WR-1:0]        m_awvalid,
    output logic [NUM_WR-1:0]        m_awready,
    input  logic [NUM_WR*DATA_W-1:0] m_wdata,
    input  logic [NUM_WR*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_WR-1:0]        m_wlast,
    input  logic [NUM_WR-1:0]        m_wvalid,
    output logic [NUM_WR-1:0]        m_wready,
    output logic [NUM_WR*2-1:0]      m_bresp,
    output logic [NUM_WR-1:0]        m_bvalid,
    input  logic [NUM_WR-1:0]        m_bready,
    // outer AR / R
    output logic [ID_W-1:0]          arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_W-1:0]          rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    // outer AW / W / B
    output logic [ID_W-1:0]          awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ID_W-1:0]          wid,
    output logic [DATA_W-1:0]        wdata,
    output logic [DATA_W/8-1:0]      wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [ID_W-1:0]          bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready,
    output logic                     err_rid
);

    // ---------------- state ----------------
    logic             rd_busy_q, rd_busy_d;
    logic [IDX_W-1:0] rd_idx_q,  rd_idx_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic             err_rid_q, err_rid_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic [IDX_W-1:0] wr_ptr_q,  wr_ptr_d;

    logic [IDX_W-1:0] rd_gnt_idx, wr_gnt_idx;
    logic             rd_gnt_valid, wr_gnt_valid;
    logic [IDX_W-1:0] r_idx;
    logic             rid_ok;

    // B is returned to the write owner, which is known from wr_idx; BID is redundant.
    logic unused_bid;
    assign unused_bid = ^bid;

    rr_arbiter #(.N(NUM_RD), .IW(IDX_W)) u_rd_arb (
        .req(m_arvalid), .ptr(rr_ptr_q), .gnt_idx(rd_gnt_idx), .gnt_valid(rd_gnt_valid)
    );

    rr_arbiter #(.N(NUM_WR), .IW(IDX_W)) u_wr_arb (
        .req(m_awvalid), .ptr(wr_ptr_q), .gnt_idx(wr_gnt_idx), .gnt_valid(wr_gnt_valid)
    );

    // ---------------- fixed AXI attributes ----------------
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'b0000;
    assign awcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;

    // ---------------- read address ----------------
    // Arbitration only happens while idle, so a handshake cycle is always
    // followed by one idle cycle before the next grant appears.
    always_comb begin
        rd_busy_d = rd_busy_q;
        rd_idx_d  = rd_idx_q;
        rr_ptr_d  = rr_ptr_q;
        if (!rd_busy_q) begin
            if (rd_gnt_valid) begin
                rd_busy_d = 1'b1;
                rd_idx_d  = rd_gnt_idx;
            end
        end else if (arready) begin
            rd_busy_d = 1'b0;
            rr_ptr_d  = IDX_W'(next_rr(int'(rd_idx_q), NUM_RD));
        end
    end

    always_comb begin
        arvalid = rd_busy_q;
        arid    = ID_W'(compose_id(MAX_ID_W'(rd_idx_q), IDX_W));
        araddr  = m_araddr[rd_idx_q*ADDR_W +: ADDR_W];
        arlen   = m_arlen[rd_idx_q*4 +: 4];
        arsize  = m_arsize[rd_idx_q*3 +: 3];
        m_arready = '0;
        m_arready[rd_idx_q] = arready & rd_busy_q;
    end

    // ---------------- read data routing ----------------
    // Data/resp are broadcast; only the addressed requester sees valid/last.
    // Beats with an unknown RID are accepted and discarded so the slave
    // cannot stall on them.
    assign r_idx  = rid[IDX_W-1:0];
    assign rid_ok = (rid < ID_W'(NUM_RD));

    always_comb begin
        m_rdata  = {NUM_RD{rdata}};
        m_rresp  = {NUM_RD{rresp}};
        m_rvalid = '0;
        m_rlast  = '0;
        rready   = 1'b1;
        if (rid_ok) begin
            m_rvalid[r_idx] = rvalid;
            m_rlast[r_idx]  = rlast;
            rready          = m_rready[r_idx];
        end
    end

    assign err_rid_d = err_rid_q | (rvalid & ~rid_ok);
    assign err_rid   = err_rid_q;

    // ---------------- write path ----------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        unique case (wr_state_q)
            W_IDLE: if (wr_gnt_valid) begin
                wr_idx_d   = wr_gnt_idx;
                wr_state_d = W_ADDR;
            end
            W_ADDR: if (awready) wr_state_d = W_DATA;
            W_DATA: if (wvalid && wready && wlast) wr_state_d = W_RESP;
            W_RESP: if (bvalid && bready) begin
                wr_ptr_d   = IDX_W'(next_rr(int'(wr_idx_q), NUM_WR));
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid   = (wr_state_q == W_ADDR);
        awid      = ID_W'(compose_id(MAX_ID_W'(wr_idx_q), IDX_W));
        wid       = awid;
        awaddr    = m_awaddr[wr_idx_q*ADDR_W +: ADDR_W];
        awlen     = m_awlen[wr_idx_q*4 +: 4];
        awsize    = m_awsize[wr_idx_q*3 +: 3];
        wdata     = m_wdata[wr_idx_q*DATA_W +: DATA_W];
        wstrb     = m_wstrb[wr_idx_q*(DATA_W/8) +: DATA_W/8];
        wlast     = m_wlast[wr_idx_q];
        wvalid    = 1'b0;
        bready    = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = {NUM_WR{bresp}};
        if (wr_state_q == W_ADDR) m_awready[wr_idx_q] = awready;
        // W is only forwarded after AW has been accepted.
        if (wr_state_q == W_DATA) begin
            wvalid             = m_wvalid[wr_idx_q];
            m_wready[wr_idx_q] = wready;
        end
        if (wr_state_q == W_RESP) begin
            bready             = m_bready[wr_idx_q];
            m_bvalid[wr_idx_q] = bvalid;
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_busy_q  <= 1'b0;
            rd_idx_q   <= '0;
            rr_ptr_q   <= '0;
            err_rid_q  <= 1'b0;
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            rd_busy_q  <= rd_busy_d;
            rd_idx_q   <= rd_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            err_rid_q  <= err_rid_d;
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

endmodule
